// File: rtl/hdmi_irq_sched_pkg.sv
// Shared constants and types for the HDMI interrupt scheduler.
// Register map, FSM state encoding and VECTOR field positions.
package hdmi_irq_sched_pkg;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_PENDING = 3'd1;
    localparam logic [2:0] REG_MASK    = 3'd2;
    localparam logic [2:0] REG_VECTOR  = 3'd3;
    localparam logic [2:0] REG_HOLDOFF = 3'd4;
    localparam logic [2:0] REG_DROPCNT = 3'd5;

    localparam int unsigned VEC_VALID_BIT = 31;
    localparam int unsigned HOLD_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_HOLDOFF
    } sched_state_e;

endpackage

// File: rtl/hdmi_irq_rr_arbiter.sv
// Combinational round-robin picker: first set req bit after index `last`,
// wrapping modulo NUM_SRC.
module hdmi_irq_rr_arbiter #(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [2:0]         last,
    output logic               any,
    output logic [2:0]         idx
);

    always_comb begin
        logic [NUM_SRC-1:0] rot;
        int unsigned        cand;
        rot  = '0;
        cand = 0;
        any  = 1'b0;
        idx  = 3'd0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            cand = (32'(last) + k) % NUM_SRC;
            rot  = req >> cand;
            if (!any && rot[0]) begin
                any = 1'b1;
                idx = 3'(cand);
            end
        end
    end

endmodule

// File: rtl/hdmi_irq_scheduler.sv
// Avalon-MM interrupt scheduler: edge capture, round-robin grant, hold-off gap.
// Optional drop counter enabled by defining HDMI_IRQ_SCHED_DROPCNT_EN.
module hdmi_irq_scheduler #(
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned HOLDOFF_RST = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               irq
);
    import hdmi_irq_sched_pkg::*;

    logic [NUM_SRC-1:0] sync1, sync2, prev;
    logic [NUM_SRC-1:0] pending, mask;
    logic [1:0]         settle;
    logic [HOLD_W-1:0]  holdoff, hold_cnt;
    logic [2:0]         grant, last_grant;
    sched_state_e       state;

    logic               wr_c, ack_c, armed_c, arb_any_c, grant_live_c;
    logic [2:0]         arb_idx_c;
    logic [NUM_SRC-1:0] fall_c, w1c_c, ack_clr_c, req_c, grant_bit_c;
    logic [HOLD_W-1:0]  drop_rd_c;
    logic [31:0]        rd_c;
    logic               unused_wdata_c;

    assign wr_c           = chipselect & ~write_n;
    assign armed_c        = (settle == 2'd3);
    assign fall_c         = armed_c ? (prev & ~sync2) : '0;
    assign ack_c          = wr_c && (address == REG_VECTOR) && (state == ST_GRANT);
    assign w1c_c          = (wr_c && address == REG_PENDING) ? writedata[NUM_SRC-1:0] : '0;
    assign grant_bit_c    = NUM_SRC'(1) << grant;
    assign ack_clr_c      = ack_c ? grant_bit_c : '0;
    assign req_c          = pending & mask;
    assign grant_live_c   = |(req_c & grant_bit_c);
    assign unused_wdata_c = ^writedata[31:HOLD_W];

    // Edge detection stays disarmed until prev holds a real synchronised sample,
    // so a line held low through reset does not look like a fresh fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= '1;
            sync2  <= '1;
            prev   <= '1;
            settle <= 2'd0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
            prev  <= sync2;
            if (!armed_c) settle <= settle + 2'd1;
        end
    end

    // A new fall wins over a same-cycle W1C or ACK clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            mask    <= '0;
            holdoff <= HOLD_W'(HOLDOFF_RST);
        end else begin
            pending <= (pending & ~w1c_c & ~ack_clr_c) | fall_c;
            if (wr_c && address == REG_MASK)    mask    <= writedata[NUM_SRC-1:0];
            if (wr_c && address == REG_HOLDOFF) holdoff <= writedata[HOLD_W-1:0];
        end
    end

    hdmi_irq_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
        .req  (req_c),
        .last (last_grant),
        .any  (arb_any_c),
        .idx  (arb_idx_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= 3'd0;
            last_grant <= 3'(NUM_SRC - 1);
            hold_cnt   <= '0;
            irq        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any_c) begin
                        grant <= arb_idx_c;
                        state <= ST_GRANT;
                        irq   <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (ack_c) begin
                        last_grant <= grant;
                        hold_cnt   <= holdoff;
                        state      <= ST_HOLDOFF;
                        irq        <= 1'b0;
                    end else if (!grant_live_c) begin
                        // Withdrawn by software: rotation pointer untouched.
                        state <= ST_IDLE;
                        irq   <= 1'b0;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt == '0) state    <= ST_IDLE;
                    else                hold_cnt <= hold_cnt - HOLD_W'(1);
                end
                default: begin
                    state <= ST_IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

`ifdef HDMI_IRQ_SCHED_DROPCNT_EN
    localparam int unsigned SUM_W = HOLD_W + 1;

    logic [HOLD_W-1:0]  drop_cnt, drop_base_c;
    logic [NUM_SRC-1:0] dropped_c;
    logic [3:0]         drop_inc_c;
    logic [SUM_W-1:0]   drop_sum_c;

    assign dropped_c = fall_c & pending;

    always_comb begin
        drop_inc_c = 4'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            drop_inc_c = drop_inc_c + 4'(dropped_c[i]);
        end
    end

    assign drop_base_c = (wr_c && address == REG_DROPCNT) ? '0 : drop_cnt;
    assign drop_sum_c  = {1'b0, drop_base_c} + SUM_W'(drop_inc_c);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_cnt <= '0;
        else       drop_cnt <= drop_sum_c[HOLD_W] ? '1 : drop_sum_c[HOLD_W-1:0];
    end

    assign drop_rd_c = drop_cnt;
`else
    assign drop_rd_c = '0;
`endif

    always_comb begin
        rd_c = '0;
        case (address)
            REG_STATUS:  rd_c = 32'(sync2);
            REG_PENDING: rd_c = 32'(pending);
            REG_MASK:    rd_c = 32'(mask);
            REG_VECTOR: begin
                if (state == ST_GRANT) begin
                    rd_c                = 32'(grant);
                    rd_c[VEC_VALID_BIT] = 1'b1;
                end
            end
            REG_HOLDOFF: rd_c = 32'(holdoff);
            REG_DROPCNT: rd_c = 32'(drop_rd_c);
            default:     rd_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           readdata <= '0;
        else if (chipselect) readdata <= rd_c;
    end

endmodule

// File: tb/tb_hdmi_irq_scheduler.sv
// Scoreboard bench for hdmi_irq_scheduler: randomized rounds checked against a
// transaction-level model of pending bits, round-robin order and hold-off timing.
module tb_hdmi_irq_scheduler;
    import hdmi_irq_sched_pkg::*;

    localparam int N     = 4;
    localparam int H_RST = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [N-1:0] irq_in;
    logic        irq;

    hdmi_irq_scheduler #(.NUM_SRC(N), .HOLDOFF_RST(H_RST)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct { int at; bit sel_rd; logic [31:0] exp; string name; } timed_t;
    typedef struct { logic [31:0] exp; string name; } rd_t;

    timed_t tq[$];
    rd_t    rq[$];
    int     cyc      = 0;
    int     n_checks = 0;
    int     n_fail   = 0;

    // Reference model state
    int         last_m = N - 1;
    logic [3:0] pend_m = 4'd0;
    logic [3:0] lines  = 4'hF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares read returns and time-stamped level expectations.
    initial begin
        bit ret;
        forever begin
            @(posedge clk);
            cyc++;
            ret = (chipselect === 1'b1) && (write_n === 1'b1);
            @(negedge clk);
            if (ret) begin
                if (rq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_read: got 0x%08h required no read", readdata);
                end else begin
                    rd_t r;
                    r = rq.pop_front();
                    check(r.name, readdata, r.exp);
                end
            end
            for (int i = tq.size() - 1; i >= 0; i--) begin
                if (tq[i].at == cyc) begin
                    check(tq[i].name, tq[i].sel_rd ? readdata : 32'(irq), tq[i].exp);
                    tq.delete(i);
                end else if (tq[i].at < cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stale_%s: got expectation for cycle %0d required >= %0d", tq[i].name, tq[i].at, cyc);
                    tq.delete(i);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int rr_pick(input logic [3:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (((req >> i) & 4'd1) != 4'd0) return i;
        end
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    task automatic expect_irq(input int at, input bit v, input string name);
        tq.push_back('{at, 1'b0, 32'(v), name});
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, output int k);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #1;
        k = cyc;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        rq.push_back('{exp, name});
        @(posedge clk); #1;
        chipselect = 1'b0;
    endtask

    // One scheduling round: lines in s fall together, grants drained in model order.
    task automatic run_round(input logic [3:0] m, input logic [3:0] s, input int h,
                             input int gap_max, input string tag);
        int n, k, idx, gap;
        logic [3:0] req;
        bus_write(REG_MASK, 32'(m), k);
        bus_write(REG_HOLDOFF, 32'(h), k);
        n = cyc;
        lines  = lines & ~s;
        irq_in = lines;
        pend_m = pend_m | s;
        req    = pend_m & m;
        if (req == 4'd0) begin
            for (int t = 1; t <= 6; t++) expect_irq(n + t, 1'b0, {tag, "_masked_quiet"});
            wait_until(n + 6);
        end else begin
            expect_irq(n + 3, 1'b0, {tag, "_irq_before_edge3"});
            expect_irq(n + 4, 1'b1, {tag, "_irq_edge3"});
            wait_until(n + 4);
        end
        while (req != 4'd0) begin
            idx = rr_pick(req, last_m);
            bus_read(REG_VECTOR, 32'h8000_0000 | 32'(idx), {tag, "_vector"});
            bus_read(REG_PENDING, 32'(pend_m), {tag, "_pending"});
            gap = $urandom_range(gap_max, 0);
            tick(gap);
            bus_write(REG_VECTOR, 32'd0, k);
            pend_m = pend_m & ~(4'd1 << idx);
            last_m = idx;
            req    = pend_m & m;
            expect_irq(k, 1'b0, {tag, "_ack_drop"});
            if (req != 4'd0) begin
                for (int t = k + 1; t <= k + h + 1; t++) expect_irq(t, 1'b0, {tag, "_holdoff_gap"});
                expect_irq(k + h + 2, 1'b1, {tag, "_regrant"});
            end else begin
                for (int t = k + 1; t <= k + h + 2; t++) expect_irq(t, 1'b0, {tag, "_drained"});
            end
            wait_until(k + h + 2);
        end
        bus_read(REG_PENDING, 32'(pend_m), {tag, "_left_pending"});
        bus_write(REG_PENDING, 32'hF, k);
        pend_m = 4'd0;
        lines  = 4'hF;
        irq_in = lines;
        bus_read(REG_PENDING, 32'd0, {tag, "_w1c"});
        tick(4);
    endtask

    initial begin
        int k, n, c;
        logic [31:0] drop_exp;
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        address = 3'd0; writedata = 32'd0; irq_in = lines;

        tq.push_back('{1, 1'b1, 32'd0, "reset_readdata"});
        expect_irq(1, 1'b0, "reset_irq");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        tick(4);

        bus_read(REG_STATUS,  32'h0000_000F, "rst_status");
        bus_read(REG_PENDING, 32'd0,         "rst_pending");
        bus_read(REG_MASK,    32'd0,         "rst_mask");
        bus_read(REG_VECTOR,  32'd0,         "rst_vector");
        bus_read(REG_HOLDOFF, 32'(H_RST),    "rst_holdoff");
        bus_read(REG_DROPCNT, 32'd0,         "rst_dropcnt");
        bus_read(3'd6,        32'd0,         "addr6_zero");
        bus_read(3'd7,        32'd0,         "addr7_zero");

        run_round(4'hF, 4'hF, 0, 0, "rr_order");
        run_round(4'h1, 4'h1, 0, 2, "single");
        run_round(4'h6, 4'h6, 10, 2, "holdoff10");

        // Grant withdrawn by clearing MASK before ACK
        bus_write(REG_HOLDOFF, 32'd0, k);
        bus_write(REG_MASK, 32'h4, k);
        n = cyc; lines[2] = 1'b0; irq_in = lines; pend_m = 4'h4;
        expect_irq(n + 4, 1'b1, "wd_irq_rise");
        wait_until(n + 4);
        bus_read(REG_VECTOR, 32'h8000_0002, "wd_vector");
        bus_read(REG_STATUS, 32'h0000_000B, "wd_status");
        bus_write(REG_MASK, 32'd0, k);
        expect_irq(k, 1'b1, "wd_irq_still_up");
        expect_irq(k + 1, 1'b0, "wd_irq_withdrawn");
        tick(1);
        bus_read(REG_VECTOR, 32'd0, "wd_vector_invalid");
        bus_read(REG_PENDING, 32'h4, "wd_pending_kept");
        bus_write(REG_PENDING, 32'h4, k);
        pend_m = 4'd0; lines[2] = 1'b1; irq_in = lines;
        tick(3);

        // Repeated falls on a pending source
        for (int p = 0; p < 3; p++) begin
            lines[1] = 1'b0; irq_in = lines; tick(3);
            lines[1] = 1'b1; irq_in = lines; tick(3);
        end
        pend_m = 4'h2;
`ifdef HDMI_IRQ_SCHED_DROPCNT_EN
        drop_exp = 32'd2;
`else
        drop_exp = 32'd0;
`endif
        bus_read(REG_DROPCNT, drop_exp, "dropcnt_three_falls");
        bus_write(REG_VECTOR, 32'd0, k);
        expect_irq(k + 1, 1'b0, "ack_outside_grant_irq");
        bus_read(REG_PENDING, 32'h2, "ack_outside_grant_pending");
        bus_write(REG_DROPCNT, 32'd0, k);
        bus_read(REG_DROPCNT, 32'd0, "dropcnt_cleared");
        bus_write(REG_PENDING, 32'hF, k);
        pend_m = 4'd0;
        tick(2);

        for (int r = 0; r < 20; r++) begin
            run_round(4'($urandom_range(15, 0)), 4'($urandom_range(15, 1)),
                      $urandom_range(4, 0), 3, $sformatf("rand%0d", r));
        end

        // Reset in the middle of a grant with line 0 held low
        bus_write(REG_HOLDOFF, 32'd0, k);
        bus_write(REG_MASK, 32'h1, k);
        n = cyc; lines[0] = 1'b0; irq_in = lines;
        expect_irq(n + 4, 1'b1, "pre_reset_grant");
        wait_until(n + 4);
        bus_read(REG_VECTOR, 32'h8000_0000, "pre_reset_vector");
        tick(1);
        reset = 1'b1;
        c = cyc;
        tq.push_back('{c, 1'b1, 32'd0, "midgrant_reset_readdata"});
        expect_irq(c, 1'b0, "midgrant_reset_irq");
        tick(2);
        reset = 1'b0;
        c = cyc; last_m = N - 1; pend_m = 4'd0;
        for (int t = 1; t <= 12; t++) expect_irq(c + t, 1'b0, "post_reset_quiet");
        bus_read(REG_PENDING, 32'd0,      "post_reset_pending");
        bus_read(REG_MASK,    32'd0,      "post_reset_mask");
        bus_read(REG_HOLDOFF, 32'(H_RST), "post_reset_holdoff");
        bus_read(REG_DROPCNT, 32'd0,      "post_reset_dropcnt");
        bus_write(REG_HOLDOFF, 32'd0, k);
        bus_write(REG_MASK, 32'h1, k);
        wait_until(c + 12);
        bus_read(REG_PENDING, 32'd0, "held_low_no_edge");
        lines[0] = 1'b1; irq_in = lines;
        tick(4);
        n = cyc; lines[0] = 1'b0; irq_in = lines;
        expect_irq(n + 3, 1'b0, "new_fall_pre");
        expect_irq(n + 4, 1'b1, "new_fall_grant");
        wait_until(n + 4);
        bus_read(REG_VECTOR, 32'h8000_0000, "new_fall_vector");
        bus_write(REG_VECTOR, 32'd0, k);
        expect_irq(k, 1'b0, "new_fall_ack");
        lines[0] = 1'b1; irq_in = lines;
        tick(6);

        if (tq.size() != 0 || rq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover_expectations: got %0d timed, %0d reads required 0", tq.size(), rq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
